// File: rtl/genius_pkg.sv
// genius_pkg: shared types and constants for the Genius game timing blocks.
`default_nettype none

package genius_pkg;

  localparam int TIME_W         = 4;
  localparam int TURN_LIMIT_DEF = 9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } turn_timer_state_t;

  // True while an armed countdown is in its final three seconds.
  function automatic logic in_warn_window(input logic busy, input logic [TIME_W-1:0] remain);
    return busy && (remain >= TIME_W'(1)) && (remain <= TIME_W'(3));
  endfunction

endpackage

`default_nettype wire

// File: rtl/genius_turn_timer_tick_gen.sv
// tick_gen: prescaler producing one tick every TICK_DIV enabled cycles.
`default_nettype none

module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk_i,
  input  logic r_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge r_n_i) begin
    if (!r_n_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // A clear in the same cycle wins over the wrap, so no tick is reported then.
  assign tick_o = en_i && !clr_i && (r_cnt == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/genius_turn_timer.sv
// genius_turn_timer: per-turn countdown with tick and timeout pulses.
// Optional warn_o output enabled by defining GENIUS_TURN_TIMER_WARN_EN.
`default_nettype none

module genius_turn_timer
  import genius_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int LIMIT    = TURN_LIMIT_DEF
) (
  input  logic              clk_i,
  input  logic              r_n_i,
  input  logic              start_i,
  input  logic              key_i,
  input  logic              stop_i,
  output logic              busy_o,
  output logic [TIME_W-1:0] remain_o,
  output logic              tick_o,
  output logic              timeout_o
`ifdef GENIUS_TURN_TIMER_WARN_EN
  ,
  output logic              warn_o
`endif
);

  localparam logic [TIME_W-1:0] LIMIT_V = TIME_W'(LIMIT);

  turn_timer_state_t r_state;
  turn_timer_state_t w_state_nxt;
  logic [TIME_W-1:0] r_remain;
  logic [TIME_W-1:0] w_remain_nxt;
  logic              r_busy;
  logic              r_tick;
  logic              r_timeout;
  logic              w_tick_nxt;
  logic              w_timeout_nxt;
  logic              w_presc_tick;
  logic              w_presc_clr;
  logic              w_presc_en;

  // Any event that restarts or ends a second also restarts the prescaler.
  assign w_presc_en  = (r_state == RUN);
  assign w_presc_clr = (r_state == IDLE) || start_i || key_i || stop_i;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .r_n_i  (r_n_i),
    .clr_i  (w_presc_clr),
    .en_i   (w_presc_en),
    .tick_o (w_presc_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_remain_nxt  = r_remain;
    w_tick_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i && !stop_i) begin
          w_state_nxt  = RUN;
          w_remain_nxt = LIMIT_V;
        end
      end
      RUN: begin
        if (stop_i) begin
          w_state_nxt = IDLE;
        end else if (start_i || key_i) begin
          w_remain_nxt = LIMIT_V;
        end else if (w_presc_tick && (r_remain != '0)) begin
          w_tick_nxt   = 1'b1;
          w_remain_nxt = r_remain - TIME_W'(1);
          if (r_remain == TIME_W'(1)) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge r_n_i) begin
    if (!r_n_i) begin
      r_state   <= IDLE;
      r_remain  <= '0;
      r_busy    <= 1'b0;
      r_tick    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_remain  <= w_remain_nxt;
      r_busy    <= (w_state_nxt == RUN);
      r_tick    <= w_tick_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign busy_o    = r_busy;
  assign remain_o  = r_remain;
  assign tick_o    = r_tick;
  assign timeout_o = r_timeout;

`ifdef GENIUS_TURN_TIMER_WARN_EN
  logic r_warn;

  always_ff @(posedge clk_i or negedge r_n_i) begin
    if (!r_n_i) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= in_warn_window(w_state_nxt == RUN, w_remain_nxt);
    end
  end

  assign warn_o = r_warn;
`endif

endmodule

`default_nettype wire

// File: tb/tb_genius_turn_timer.sv
// Bench for genius_turn_timer with TICK_DIV=4, LIMIT=3: directed table plus random traffic.
`default_nettype none

module tb_genius_turn_timer;

  localparam int TD  = 4;
  localparam int LIM = 3;

  logic       clk_i   = 1'b0;
  logic       r_n_i   = 1'b0;
  logic       start_i = 1'b0;
  logic       key_i   = 1'b0;
  logic       stop_i  = 1'b0;
  logic       busy_o;
  logic [3:0] remain_o;
  logic       tick_o;
  logic       timeout_o;
`ifdef GENIUS_TURN_TIMER_WARN_EN
  logic       warn_o;
`endif

  genius_turn_timer #(
    .TICK_DIV (TD),
    .LIMIT    (LIM)
  ) dut (
    .clk_i     (clk_i),
    .r_n_i     (r_n_i),
    .start_i   (start_i),
    .key_i     (key_i),
    .stop_i    (stop_i),
    .busy_o    (busy_o),
    .remain_o  (remain_o),
    .tick_o    (tick_o),
    .timeout_o (timeout_o)
`ifdef GENIUS_TURN_TIMER_WARN_EN
    ,
    .warn_o    (warn_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Deadline-based reference: an armed turn owns the absolute edge of its next tick.
  bit     m_armed;
  int     m_remain;
  longint m_next;
  bit     m_tick;
  bit     m_timeout;
  longint edge_n = 0;

  task automatic model_reset();
    m_armed = 0; m_remain = 0; m_next = 0; m_tick = 0; m_timeout = 0;
  endtask

  task automatic model_edge(input bit s, input bit k, input bit p);
    m_tick = 0; m_timeout = 0;
    if (!m_armed) begin
      if (s && !p) begin
        m_armed = 1; m_remain = LIM; m_next = edge_n + TD;
      end
    end else if (p) begin
      m_armed = 0;
    end else if (s || k) begin
      m_remain = LIM; m_next = edge_n + TD;
    end else if (edge_n == m_next) begin
      m_tick = 1; m_remain = m_remain - 1; m_next = m_next + TD;
      if (m_remain == 0) begin
        m_timeout = 1; m_armed = 0;
      end
    end
  endtask

  task automatic check(input string name, input bit b, input int r, input bit t, input bit to);
    bit ok;
    ok = (busy_o === b) && (remain_o === 4'(r)) && (tick_o === t) && (timeout_o === to);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s @edge %0d: busy/remain/tick/timeout got %b/%0d/%b/%b want %b/%0d/%b/%b",
                  name, edge_n, busy_o, remain_o, tick_o, timeout_o, b, r, t, to);
`ifdef GENIUS_TURN_TIMER_WARN_EN
    n_checks++;
    if (warn_o === (b && r >= 1 && r <= 3)) n_pass++;
    else $display("FAIL %s_warn @edge %0d: warn got %b want %b", name, edge_n, warn_o,
                  (b && r >= 1 && r <= 3));
`endif
  endtask

  task automatic step(input bit s, input bit k, input bit p);
    start_i = s; key_i = k; stop_i = p;
    @(posedge clk_i);
    edge_n++;
    model_edge(s, k, p);
    #1;
    start_i = 0; key_i = 0; stop_i = 0;
  endtask

  typedef struct {
    bit s, k, p;
    bit b;
    int r;
    bit t, to;
    string name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string nm, input bit s, input bit k, input bit p,
                              input bit b, input int r, input bit t, input bit to);
    vec_t v;
    v.name = nm; v.s = s; v.k = k; v.p = p; v.b = b; v.r = r; v.t = t; v.to = to;
    tbl.push_back(v);
  endfunction

  function automatic void add_hold(input string nm, input int n, input bit b, input int r);
    for (int i = 0; i < n; i++) add(nm, 0, 0, 0, b, r, 0, 0);
  endfunction

  initial begin
    // Free-running countdown
    add("free_start", 1, 0, 0, 1, 3, 0, 0);  add_hold("free_r3", 3, 1, 3);
    add("free_tick1", 0, 0, 0, 1, 2, 1, 0);  add_hold("free_r2", 3, 1, 2);
    add("free_tick2", 0, 0, 0, 1, 1, 1, 0);  add_hold("free_r1", 3, 1, 1);
    add("free_tmo",   0, 0, 0, 0, 0, 1, 1);  add_hold("free_idle", 2, 0, 0);
    // Key restart
    add("key_start",  1, 0, 0, 1, 3, 0, 0);  add_hold("key_r3a", 3, 1, 3);
    add("key_tick0",  0, 0, 0, 1, 2, 1, 0);  add_hold("key_r2a", 2, 1, 2);
    add("key_press",  0, 1, 0, 1, 3, 0, 0);  add_hold("key_r3", 3, 1, 3);
    add("key_tick1",  0, 0, 0, 1, 2, 1, 0);  add_hold("key_r2", 3, 1, 2);
    add("key_tick2",  0, 0, 0, 1, 1, 1, 0);  add_hold("key_r1", 3, 1, 1);
    add("key_tmo",    0, 0, 0, 0, 0, 1, 1);  add_hold("key_idle", 1, 0, 0);
    // Stop mid-run
    add("stop_start", 1, 0, 0, 1, 3, 0, 0);  add_hold("stop_r3", 3, 1, 3);
    add("stop_tick",  0, 0, 0, 1, 2, 1, 0);
    add("stop_now",   0, 0, 1, 0, 2, 0, 0);  add_hold("stop_quiet", 9, 0, 2);
    // Simultaneous events
    add("sim_start",  1, 0, 0, 1, 3, 0, 0);  add_hold("sim_r3", 3, 1, 3);
    add("sim_keytick",0, 1, 0, 1, 3, 0, 0);
    add("sim_stopkey",0, 1, 1, 0, 3, 0, 0);
    add("sim_ststop", 1, 0, 1, 0, 3, 0, 0);  add_hold("sim_idle", 5, 0, 3);
    add("idle_key",   0, 1, 0, 0, 3, 0, 0);
    add("idle_stop",  0, 0, 1, 0, 3, 0, 0);

    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_state", 0, 0, 0, 0);
    r_n_i = 1'b1;
    step(0, 0, 0);
    check("after_reset", 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s, tbl[i].k, tbl[i].p);
      check(tbl[i].name, tbl[i].b, tbl[i].r, tbl[i].t, tbl[i].to);
    end

    // Asynchronous reset in the middle of a countdown
    step(1, 0, 0);
    check("rst_arm", 1, 3, 0, 0);
    repeat (5) step(0, 0, 0);
    check("rst_pre", 1, 2, 0, 0);
    @(posedge clk_i);
    edge_n++;
    #2 r_n_i = 1'b0;
    #1 check("rst_async", 0, 0, 0, 0);
    model_reset();
    #3 r_n_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, $urandom_range(0, 1) == 0, 0);
      check("rst_quiet", 0, 0, 0, 0);
    end

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
      check("random", m_armed, m_remain, m_tick, m_timeout);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/genius_turn_timer.md
# genius_turn_timer

Player-turn timeout controller for the Genius game. It generates the per-second time base from the system clock and counts down the seconds the player has left to press the next button. Every key press reloads the countdown. Expiry produces a one-cycle timeout pulse. The game FSM drives this block through the arm, key and stop pulses and consumes the timeout; `remain_o` feeds the time display.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per second tick; legal range ≥ 2.
- `LIMIT`, default 9: seconds allowed per key press; legal range 1..15.
- `clk_i`  in  1  system clock; all state changes on the rising edge.
- `r_n_i`  in  1  reset; **one clock; reset is asynchronous and active-low**.
- `start_i`  in  1  one-cycle pulse: arm the timer at the start of a player turn.
- `key_i`  in  1  one-cycle pulse: the player pressed a button.
- `stop_i`  in  1  one-cycle pulse: the turn is over; disarm.
- `busy_o`  out  1  high while the timer is armed.
- `remain_o`  out  4  seconds remaining, unsigned.
- `tick_o`  out  1  one-cycle pulse per elapsed second while armed.
- `timeout_o`  out  1  one-cycle pulse when the countdown reaches 0.

## Operation
- Two states:
  - `IDLE`: reset state; the prescaler is held at 0.
  - `RUN`: the prescaler counts 0..TICK_DIV-1 and wraps to 0.
- `IDLE` transitions:
  - `start_i` → `RUN`, `remain_o`=LIMIT, prescaler=0.
  - `key_i` is ignored.
  - `stop_i` is a no-op.
- `RUN` events are evaluated in priority order; only the highest-priority event acts in a cycle:
  1. `stop_i` → `IDLE`. `remain_o` keeps its value. No tick or timeout is issued that cycle.
  2. `start_i` or `key_i` → `remain_o`=LIMIT, prescaler=0. Any tick due that cycle is suppressed.
  3. Prescaler == TICK_DIV-1 → `tick_o`=1 and `remain_o` decrements by 1. If `remain_o` was 1, it becomes 0, `timeout_o`=1, and the state → `IDLE`.
- `remain_o` never wraps below 0 and never exceeds LIMIT.
- A simultaneous `start_i` and `stop_i` in `IDLE` leaves the block in `IDLE`: stop wins.
- Reset values, applied at any time including mid-countdown:
  - state `IDLE`, prescaler 0.
  - `busy_o`=0, `remain_o`=0, `tick_o`=0, `timeout_o`=0.
- All outputs are registered. `busy_o` is 1 exactly when the state is `RUN`.

## Timing
- `start_i` sampled at edge k:
  - `busy_o`=1 and `remain_o`=LIMIT from edge k.
  - Ticks occur at edges k+n·TICK_DIV, for n=1..LIMIT.
- Timeout with no key press: `timeout_o`=1, `busy_o`=0 and `remain_o`=0, all at edge k+LIMIT·TICK_DIV.
- `key_i` at edge j restarts the schedule exactly as a `start_i` at edge j would.
- `tick_o` and `timeout_o` are high for exactly one cycle.
- Latency from any input pulse to the affected output is one edge.

## Configuration
- `GENIUS_TURN_TIMER_WARN_EN` defined:
  - Adds output `warn_o` (1 bit, reset 0).
  - `warn_o` is registered high while `busy_o`=1 and 1 ≤ `remain_o` ≤ 3; otherwise low.
  - It updates on the same edge as `remain_o`.
- Macro undefined: the port `warn_o` and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `genius_pkg` holds:
  - the state typedef `turn_timer_state_t` (`IDLE`, `RUN`);
  - `TIME_W` = 4;
  - the default per-turn limit constant `TURN_LIMIT_DEF` = 9.
- Sub-module `tick_gen`:
  - parameterised prescaler with inputs `clk_i`, `r_n_i`, `clr_i`, `en_i` and output `tick_o`;
  - counter width `$clog2(TICK_DIV)`.
- The top level holds the FSM and the `remain_o` register.

## Test plan
All scenarios use TICK_DIV=4 and LIMIT=3.
- **Free-running countdown:** `start_i` at edge 10 → `tick_o` at edges 14, 18, 22; `remain_o` 3→2→1→0; `timeout_o` and `busy_o`=0 at edge 22.
- **Key restart:** `start_i` at edge 10, `key_i` at edge 17 → `remain_o` back to 3 at edge 17; next ticks at 21, 25, 29; timeout at 29.
- **Stop mid-run:** `start_i` at 10, `stop_i` at 15 → `busy_o`=0 at 15; `remain_o` holds 2; no tick or timeout afterwards.
- **Simultaneous events:** `key_i` on a tick edge (edge 14) → no `tick_o`, `remain_o`=3. `stop_i` with `key_i` → `IDLE`. `start_i`+`stop_i` in `IDLE` → stays `IDLE`.
- **Reset mid-operation:** `r_n_i` low asynchronously at 2 ns past edge 16 → all outputs 0 immediately; no pulses until the next `start_i`.
- **Warning output** (`GENIUS_TURN_TIMER_WARN_EN` defined): `warn_o`=1 from edge 10 through edge 21, and 0 at edge 22.
